// File: rtl/cpu_types_pkg.sv
// Shared bus types: data word, RAM handshake state and bus FSM states.
// Used by cache_bus_ctrl and bus_arbiter.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [3:0] {
      IDLE, ARB, SNOOP, C2C1, C2C2,
      RAM1, RAM2, WB1, WB2, IFETCH
   } bus_state_t;

   // Select word 0/1 of a two-word block by forcing address bit 2
   function automatic word_t blk_word(word_t a, logic w);
      return (a & ~32'h4) | {29'd0, w, 2'd0};
   endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-way grant selection for the coherence bus.
// BUS_ROUNDROBIN_EN: alternate ties; otherwise core 0 wins ties.
module bus_arbiter (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt,
   output logic       ptr_nxt
);

`ifdef BUS_ROUNDROBIN_EN
   // ptr names the core holding priority; the winner yields it
   always_comb begin
      gnt     = req;
      ptr_nxt = ptr;
      if (req == 2'b11)
         gnt = ptr ? 2'b10 : 2'b01;
      if (gnt[1])
         ptr_nxt = 1'b0;
      else if (gnt[0])
         ptr_nxt = 1'b1;
   end
`else
   always_comb begin
      gnt     = 2'b00;
      ptr_nxt = ptr;
      if (req[0])
         gnt = 2'b01;
      else if (req[1])
         gnt = 2'b10;
   end
`endif

endmodule

// File: rtl/cache_bus_ctrl.sv
// Two-core coherence bus: snoops, cache-to-cache transfer, RAM fills,
// write-backs and instruction fetch. Round-robin ties: BUS_ROUNDROBIN_EN.
module cache_bus_ctrl
   import cpu_types_pkg::*;
#(
   parameter int NCORE = 2
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NCORE-1:0]            dREN,
   input  logic [NCORE-1:0]            dWEN,
   input  logic [NCORE-1:0]            cctrans,
   input  logic [NCORE-1:0]            ccwrite,
   input  logic [NCORE-1:0][31:0]      daddr,
   input  logic [NCORE-1:0][31:0]      dstore,
   output logic [NCORE-1:0][31:0]      dload,
   output logic [NCORE-1:0]            dwait,
   output logic [NCORE-1:0]            ccwait,
   output logic [NCORE-1:0]            ccinv,
   output logic [NCORE-1:0][31:0]      ccsnoopaddr,
   input  logic [NCORE-1:0]            iREN,
   input  logic [NCORE-1:0][31:0]      iaddr,
   output logic [NCORE-1:0][31:0]      iload,
   output logic [NCORE-1:0]            iwait,
   output logic                        ramREN,
   output logic                        ramWEN,
   output logic [31:0]                 ramaddr,
   output logic [31:0]                 ramstore,
   input  logic [31:0]                 ramload,
   input  logic [1:0]                  ramstate
);

   bus_state_t state, nxt;
   ramstate_t  rs;
   logic       acc;
   logic       req_q, s;
   word_t      addr_q;
   logic       ccw_q;
   logic       ptr_q, ptr_nxt;
   logic [1:0] dreq, arb_req, gnt;
   logic       gidx;
   logic       dren_unused;

   // reads arrive as coherence transactions, so dREN carries no extra info
   assign dren_unused = ^dREN;

   assign rs      = ramstate_t'(ramstate);
   assign acc     = (rs == ACCESS);
   assign s       = ~req_q;
   assign dreq    = cctrans | dWEN;
   assign arb_req = (state == IDLE) ? iREN : dreq;
   assign gidx    = gnt[1];

   bus_arbiter u_arb (
      .req     (arb_req),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .ptr_nxt (ptr_nxt)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         req_q  <= 1'b0;
         addr_q <= '0;
         ccw_q  <= 1'b0;
         ptr_q  <= 1'b0;
      end else if (state == ARB && |dreq) begin
         req_q  <= gidx;
         addr_q <= daddr[gidx];
         ccw_q  <= ccwrite[gidx];
         ptr_q  <= ptr_nxt;
      end else if (state == IDLE && nxt == IFETCH) begin
         req_q  <= gidx;
         ptr_q  <= ptr_nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:
            if (|dreq)
               nxt = ARB;
            else if (|iREN)
               nxt = IFETCH;
         ARB:
            if (!(|dreq))
               nxt = IDLE;
            else if (cctrans[gidx])
               nxt = SNOOP;
            else
               nxt = WB1;
         SNOOP:
            if (cctrans[s] && ccwrite[s])
               nxt = C2C1;
            else if (cctrans[s])
               nxt = RAM1;
         C2C1:   if (acc) nxt = C2C2;
         C2C2:   if (acc) nxt = IDLE;
         RAM1:   if (acc) nxt = RAM2;
         RAM2:   if (acc) nxt = IDLE;
         WB1:    if (acc) nxt = WB2;
         WB2:    if (acc) nxt = IDLE;
         IFETCH: if (acc) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // a faulted RAM freezes the bus where it is
      if (rs == ERROR)
         nxt = state;
   end

   always_comb begin
      dload       = '0;
      dwait       = '1;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      iload       = '0;
      iwait       = '1;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      unique case (state)
         SNOOP, C2C1, C2C2, RAM1, RAM2: begin
            ccwait[s]      = 1'b1;
            ccinv[s]       = ccw_q;
            ccsnoopaddr[s] = addr_q;
         end
         default: ;
      endcase
      unique case (state)
         C2C1, C2C2: begin
            ramWEN       = 1'b1;
            ramaddr      = daddr[s];
            ramstore     = dstore[s];
            dload[req_q] = dstore[s];
            if (acc) begin
               dwait[req_q] = 1'b0;
               dwait[s]     = 1'b0;
            end
         end
         RAM1, RAM2: begin
            ramREN       = 1'b1;
            ramaddr      = blk_word(addr_q, state == RAM2);
            dload[req_q] = ramload;
            if (acc)
               dwait[req_q] = 1'b0;
         end
         WB1, WB2: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr[req_q];
            ramstore = dstore[req_q];
            if (acc)
               dwait[req_q] = 1'b0;
         end
         IFETCH: begin
            ramREN       = 1'b1;
            ramaddr      = iaddr[req_q];
            iload[req_q] = ramload;
            if (acc)
               iwait[req_q] = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_bus_ctrl.sv
// Self-checking bench for cache_bus_ctrl: IDLE decision table plus
// scoreboarded RAM traffic for snoop, transfer, write-back and fetch.
module tb_cache_bus_ctrl;

   logic              CLK = 1'b0;
   logic              RST;
   logic [1:0]        dREN, dWEN, cctrans, ccwrite, iREN;
   logic [1:0][31:0]  daddr, dstore, iaddr;
   logic [1:0][31:0]  dload, iload, ccsnoopaddr;
   logic [1:0]        dwait, ccwait, ccinv, iwait;
   logic              ramREN, ramWEN;
   logic [31:0]       ramaddr, ramstore, ramload;
   logic [1:0]        ramstate;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1;
   localparam logic [1:0] ACC = 2'd2, ERR = 2'd3;

   cache_bus_ctrl #(.NCORE(2)) dut (
      .CLK(CLK), .RST(RST),
      .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
      .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   // RAM contents: a fixed function of the address
   assign ramload = ramaddr ^ 32'hA5A5_0000;

   typedef struct {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      int          port;   // 0 none, 1 dload+dwait, 2 iload+iwait, 3 dwait
      int          core;
      logic [31:0] dl;
   } sb_t;

   sb_t sbq[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic push(logic r, logic w, logic [31:0] a, logic [31:0] st,
                       int p, int c, logic [31:0] d);
      sb_t e;
      e.ren = r; e.wen = w; e.addr = a; e.store = st;
      e.port = p; e.core = c; e.dl = d;
      sbq.push_back(e);
   endtask

   function automatic logic [31:0] mem(logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(negedge CLK) begin
      if (!RST && (ramREN || ramWEN) && ramstate == ACC) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ram actual=%h expected=none", ramaddr);
         end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("ram_ren", ramREN, e.ren);
            chk("ram_wen", ramWEN, e.wen);
            chk("ram_addr", ramaddr, e.addr);
            if (e.wen) chk("ram_store", ramstore, e.store);
            if (e.port == 1) chk("dload", dload[e.core], e.dl);
            if (e.port == 1 || e.port == 3) begin
               chk("dwait_done", dwait[e.core], 1'b0);
               chk("iwait_held", iwait, 2'b11);
            end
            if (e.port == 2) begin
               chk("iload", iload[e.core], e.dl);
               chk("iwait_done", iwait[e.core], 1'b0);
               chk("dwait_held", dwait, 2'b11);
            end
         end
      end
   end

   task automatic clr_in();
      dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; iREN = '0;
      daddr = '0; dstore = '0; iaddr = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clr_in();
      ramstate = FREE;
      sbq.delete();
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic wait_q(int n, int budget, string nm);
      int k = 0;
      while (sbq.size() > n && k < budget) begin
         @(negedge CLK);
         #1;
         k++;
      end
      checks++;
      if (sbq.size() > n) begin
         errors++;
         $display("FAIL %s timeout actual=%0d expected=%0d", nm, sbq.size(), n);
      end
   endtask

   task automatic wait_snoop(int c, string nm);
      for (int k = 0; k < 20 && !ccwait[c]; k++) @(negedge CLK);
      chk(nm, ccwait, (c == 1) ? 2'b10 : 2'b01);
   endtask

   task automatic chk_idle(string nm);
      @(negedge CLK);
      chk({nm, "_ccwait"}, ccwait, 2'b00);
      chk({nm, "_dwait"}, dwait, 2'b11);
      chk({nm, "_iwait"}, iwait, 2'b11);
   endtask

   typedef struct {
      logic [1:0]  ct, cw, dw, ir;
      logic [1:0]  e_ccw, e_inv;
      logic        e_ren, e_wen;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vt[12];

   initial begin
      vt[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0};
      vt[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0, 32'h0};
      vt[2]  = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 32'h0};
      vt[3]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 32'h1000};
      vt[4]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 32'h3000};
      vt[5]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0, 32'h4000};
      vt[6]  = '{2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 0, 0, 32'h0};
      vt[7]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0, 32'h0};
      vt[8]  = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1, 32'h2000};
      vt[9]  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 32'h3000};
      vt[10] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 32'h0};
      vt[11] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 32'h1000};

      RST = 1'b1;
      clr_in();
      ramstate = FREE;
      @(negedge CLK);
      chk("rst_dwait", dwait, 2'b11);
      chk("rst_iwait", iwait, 2'b11);
      chk("rst_ccwait", ccwait, 2'b00);
      chk("rst_ramren", ramREN, 1'b0);
      chk("rst_ramwen", ramWEN, 1'b0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_dload", dload, 64'h0);

      // decision table: state two cycles after leaving reset
      for (int i = 0; i < 12; i++) begin
         do_reset();
         daddr[0] = 32'h1000; daddr[1] = 32'h2000;
         iaddr[0] = 32'h3000; iaddr[1] = 32'h4000;
         cctrans = vt[i].ct; dREN = vt[i].ct; ccwrite = vt[i].cw;
         dWEN = vt[i].dw; iREN = vt[i].ir;
         repeat (2) @(negedge CLK);
         chk($sformatf("vec%0d_ccwait", i), ccwait, vt[i].e_ccw);
         chk($sformatf("vec%0d_ccinv", i), ccinv, vt[i].e_inv);
         chk($sformatf("vec%0d_ramren", i), ramREN, vt[i].e_ren);
         chk($sformatf("vec%0d_ramwen", i), ramWEN, vt[i].e_wen);
         chk($sformatf("vec%0d_ramaddr", i), ramaddr, vt[i].e_addr);
         chk($sformatf("vec%0d_dwait", i), dwait, 2'b11);
         chk($sformatf("vec%0d_iwait", i), iwait, 2'b11);
      end

      // clean snoop miss: fill from RAM
      do_reset();
      ramstate = ACC;
      daddr[0] = 32'h100; cctrans[0] = 1'b1; dREN[0] = 1'b1;
      push(1, 0, 32'h100, 0, 1, 0, mem(32'h100));
      push(1, 0, 32'h104, 0, 1, 0, mem(32'h104));
      wait_snoop(1, "miss_ccwait");
      chk("miss_ccinv", ccinv, 2'b00);
      chk("miss_snpaddr", ccsnoopaddr[1], 32'h100);
      cctrans[1] = 1'b1;
      wait_q(0, 20, "miss_fill");
      clr_in();
      chk_idle("miss_end");

      // write intent, dirty copy in core 1: cache-to-cache
      do_reset();
      ramstate = ACC;
      daddr[0] = 32'h200; cctrans[0] = 1'b1; ccwrite[0] = 1'b1;
      push(0, 1, 32'h200, 32'hAAAA_0001, 1, 0, 32'hAAAA_0001);
      push(0, 1, 32'h204, 32'hBBBB_0002, 1, 0, 32'hBBBB_0002);
      wait_snoop(1, "c2c_ccwait");
      chk("c2c_ccinv", ccinv, 2'b10);
      cctrans[1] = 1'b1; ccwrite[1] = 1'b1;
      daddr[1] = 32'h200; dstore[1] = 32'hAAAA_0001;
      wait_q(1, 20, "c2c_w0");
      daddr[1] = 32'h204; dstore[1] = 32'hBBBB_0002;
      wait_q(0, 20, "c2c_w1");
      clr_in();
      chk_idle("c2c_end");

      // simultaneous requests: second grant depends on arbitration mode
      do_reset();
      ramstate = ACC;
      cctrans = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600;
      push(1, 0, 32'h500, 0, 1, 0, mem(32'h500));
      push(1, 0, 32'h504, 0, 1, 0, mem(32'h504));
`ifdef BUS_ROUNDROBIN_EN
      push(1, 0, 32'h600, 0, 1, 1, mem(32'h600));
      push(1, 0, 32'h604, 0, 1, 1, mem(32'h604));
`else
      push(1, 0, 32'h500, 0, 1, 0, mem(32'h500));
      push(1, 0, 32'h504, 0, 1, 0, mem(32'h504));
`endif
      wait_q(0, 40, "tie_grants");
      clr_in();
      chk_idle("tie_end");

      // write-back on core 1 beats instruction fetch on core 0
      do_reset();
      ramstate = ACC;
      dWEN[1] = 1'b1; daddr[1] = 32'h300; dstore[1] = 32'hC0C0_0003;
      iREN[0] = 1'b1; iaddr[0] = 32'h400;
      push(0, 1, 32'h300, 32'hC0C0_0003, 3, 1, 0);
      push(0, 1, 32'h304, 32'hD0D0_0004, 3, 1, 0);
      push(1, 0, 32'h400, 0, 2, 0, mem(32'h400));
      wait_q(2, 20, "wb_w0");
      daddr[1] = 32'h304; dstore[1] = 32'hD0D0_0004;
      wait_q(1, 20, "wb_w1");
      dWEN = '0;
      wait_q(0, 20, "wb_ifetch");
      clr_in();
      chk_idle("wb_end");

      // reset in the middle of a cache-to-cache transfer
      do_reset();
      ramstate = BUSY;
      daddr[0] = 32'h700; cctrans[0] = 1'b1; ccwrite[0] = 1'b1;
      wait_snoop(1, "rst_mid_ccwait");
      cctrans[1] = 1'b1; ccwrite[1] = 1'b1;
      daddr[1] = 32'h700; dstore[1] = 32'h1234_5678;
      for (int k = 0; k < 20 && !ramWEN; k++) @(negedge CLK);
      chk("rst_mid_inc2c", ramWEN, 1'b1);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_mid_ramwen", ramWEN, 1'b0);
      chk("rst_mid_ccwait", ccwait, 2'b00);
      chk("rst_mid_dwait", dwait, 2'b11);
      chk("rst_mid_iwait", iwait, 2'b11);
      clr_in();
      RST = 1'b0;
      chk_idle("rst_mid_end");

      // RAM stalls, then faults, during a fill
      do_reset();
      ramstate = BUSY;
      daddr[0] = 32'h800; cctrans[0] = 1'b1;
      wait_snoop(1, "busy_ccwait");
      cctrans[1] = 1'b1;
      for (int k = 0; k < 20 && !ramREN; k++) @(negedge CLK);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("busy_dwait", dwait[0], 1'b1);
         chk("busy_ramaddr", ramaddr, 32'h800);
      end
      ramstate = ERR;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         chk("err_dwait", dwait, 2'b11);
         chk("err_ramaddr", ramaddr, 32'h800);
      end
      push(1, 0, 32'h800, 0, 1, 0, mem(32'h800));
      push(1, 0, 32'h804, 0, 1, 0, mem(32'h804));
      ramstate = ACC;
      wait_q(0, 20, "busy_fill");
      clr_in();
      chk_idle("busy_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_bus_ctrl.md
CACHE_BUS_CTRL -- requirements
Module: cache_bus_ctrl

Interface
REQ-001 SHALL have parameter NCORE, default 2, meaning number of cores (each with one dcache and one icache); only 2 supported.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports dREN, dWEN, cctrans, ccwrite  input  [1:0]  per-core dcache read, write, coherence-transaction and write-intent requests.
REQ-005 SHALL have ports daddr, dstore  input  [1:0] x 32  per-core dcache address and write data.
REQ-006 SHALL have ports dload  output  [1:0] x 32, and dwait  output  [1:0]  per-core read data and stall.
REQ-007 SHALL have ports ccwait, ccinv  output  [1:0], and ccsnoopaddr  output  [1:0] x 32  snoop request, invalidate and snoop address to each dcache.
REQ-008 SHALL have ports iREN  input  [1:0]; iaddr  input  [1:0] x 32; iload  output  [1:0] x 32; iwait  output  [1:0]  per-core instruction fetch.
REQ-009 SHALL have ports ramREN, ramWEN  output  1; ramaddr, ramstore  output  32; ramload  input  32; ramstate  input  2 (FREE, BUSY, ACCESS, ERROR)  RAM side.

Function
REQ-010 SHALL implement states IDLE, ARB, SNOOP, C2C1, C2C2, RAM1, RAM2, WB1, WB2, IFETCH.
REQ-011 SHALL, in IDLE, go to ARB when any cctrans or dWEN is high, else to IFETCH when any iREN is high, else stay.
REQ-012 SHALL, in ARB, grant one dcache requester (requester R, other core S), latch R's daddr and ccwrite, and go to SNOOP if R has cctrans, else (plain write-back) to WB1.
REQ-013 SHALL, in SNOOP, drive ccwait[S]=1, ccsnoopaddr[S]=latched address, ccinv[S]=latched ccwrite; on cctrans[S]&ccwrite[S] (S dirty) go to C2C1; on cctrans[S]&!ccwrite[S] go to RAM1; else hold.
REQ-014 SHALL, in C2C1/C2C2, forward S's dstore to dload[R] for words 0/1 and write the same word to RAM (ramWEN, ramaddr=S daddr), deasserting dwait[R] and dwait[S] in the cycle ramstate==ACCESS, then advance.
REQ-015 SHALL, in RAM1/RAM2, read words 0/1 (ramaddr = latched address with bit 2 = 0/1), drive dload[R]=ramload, deasserting dwait[R] only when ramstate==ACCESS.
REQ-016 SHALL, in WB1/WB2, pass R's dstore/daddr to RAM with ramWEN, dwait[R]=0 only when ramstate==ACCESS.
REQ-017 SHALL, in IFETCH, serve one iREN requester (ramREN, ramaddr=iaddr), iwait low and iload=ramload when ramstate==ACCESS, then return to IDLE.
REQ-018 SHALL return to IDLE after C2C2, RAM2, WB2; ccwait to S SHALL drop in the cycle after C2C2/RAM2 completes.
REQ-019 SHALL drive all dwait/iwait high except in the completion cycle above; never assert ramREN and ramWEN together.
REQ-020 SHALL, on ramstate==ERROR, hold the current state with waits asserted.
REQ-021 SHALL give dcache traffic priority over icache when both request in IDLE.
REQ-022 SHALL never snoop the requester itself; simultaneous cctrans from both cores SHALL be serialized, loser keeping dwait high.

Reset
REQ-023 SHALL on RST enter IDLE, clear latched address/requester/priority pointer, drive ccwait=0, ccinv=0, ccsnoopaddr=0, dload=0, iload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, dwait='1, iwait='1.
REQ-024 SHALL abandon any in-flight transaction on RST mid-operation; no partial RAM write beyond the current cycle.

Configuration
REQ-025 SHALL, with BUS_ROUNDROBIN_EN defined, alternate grant in ARB and IFETCH between cores (last-granted gets lowest priority).
REQ-026 SHALL, without BUS_ROUNDROBIN_EN, use fixed priority: core 0 always wins ties.

Structure
REQ-027 SHALL take word_t, ramstate_t and the bus state enum from cpu_types_pkg.
REQ-028 SHALL place grant selection in sub-module bus_arbiter (two request bits in, one-hot grant plus pointer update out).

Verification
REQ-029 Core0 cctrans/ccwrite=0 read 0x100, core1 miss -> ccwait[1]=1, ccinv[1]=0, RAM reads 0x100 then 0x104, dload[0]=ramload.
REQ-030 Core0 write-intent to 0x200, core1 holds it dirty (data A,B) -> ccinv[1]=1, dload[0]=A then B, RAM written 0x200=A, 0x204=B.
REQ-031 Both cores cctrans same cycle, round-robin build -> grants 0 then 1; fixed build twice -> core 0 first both times.
REQ-032 dWEN core1 and iREN core0 together -> write-back 0x300 completes before any iwait[0] low.
REQ-033 RST asserted during C2C1 -> next cycle IDLE, ramWEN=0, ccwait=0, all waits high.
REQ-034 ramstate held BUSY 5 cycles in RAM1 -> dwait stays high, state unchanged until ACCESS.
